pipe_stage_buf: RTL and testbench

- Parametrised, elastic inter-stage pipeline buffer for the 5-stage core (IF/ID, ID/EX, ...); generalises a fixed single-entry stage register.
- Carries instruction word, PC+2 and an error sideband through a DEPTH-entry FIFO with valid/ready handshake.
- Supports flush (branch/jump taken), sticky halt capture, and NOP bubble output when empty.
- Sits between a producing stage and a consuming stage; replaces ad-hoc stall muxing with registered backpressure.

---
 rtl/pipe_stage_buf_pkg.sv | 17 +
 rtl/pipe_stage_buf_fifo.sv | 48 ++++
 rtl/pipe_stage_buf.sv | 107 ++++++++++
 tb/tb_pipe_stage_buf.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants, state encoding and sizing helper for the pipe_stage_buf elastic stage buffer.
package pipe_pkg;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0800;
  localparam int          MAX_DEPTH    = 8;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  // A single-entry buffer still needs a 1-bit pointer to keep the ports legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_fifo.sv
// Storage, pointers and occupancy count for pipe_stage_buf; DEPTH need not be a power of two.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter  int W     = 34,
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     r_mem [0:DEPTH-1];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage pipeline buffer: valid/ready FIFO with flush, sticky halt and NOP bubbles.
// Optional perf counters (stall_cnt, bubble_cnt) enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                PC_W     = 16,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_err,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_err,
  output logic              out_halt,
  output logic              halted
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  localparam int               W       = DATA_W + PC_W + 2;
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] w_count;
  logic [W-1:0]     w_rd_data;
  logic             w_push;
  logic             w_pop;
  logic             w_head_valid;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready     = (w_count < DEPTH_C) && (r_state == ST_RUN);
  assign w_head_valid = (w_count != '0);
  assign w_push       = in_valid && in_ready;
  assign w_pop        = out_valid && out_ready;

  pipe_stage_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .push    (w_push && !flush),
    .pop     (w_pop && !flush),
    .wr_data ({in_err, in_halt, in_pc, in_inst}),
    .rd_data (w_rd_data),
    .count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    halted       = (r_state == ST_HALTED);
    out_valid    = w_head_valid;
    out_inst     = NOP_WORD;
    out_pc       = '0;
    out_err      = 1'b0;
    out_halt     = 1'b0;
    if (flush) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN && w_push && in_halt) begin
      w_state_next = ST_HALTED;
    end
    if (w_head_valid) begin
      out_inst = w_rd_data[DATA_W-1:0];
      out_pc   = w_rd_data[DATA_W +: PC_W];
      out_halt = w_rd_data[DATA_W + PC_W];
      out_err  = w_rd_data[DATA_W + PC_W + 1];
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (!out_valid && r_state == ST_RUN && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 instance for handshake/flush/halt, DEPTH=3 for wrap.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  int          errors;
  int          checks;

  logic        a_flush, a_in_valid, a_in_ready, a_in_err, a_in_halt;
  logic        a_out_valid, a_out_ready, a_out_err, a_out_halt, a_halted;
  logic [15:0] a_in_inst, a_in_pc, a_out_inst, a_out_pc;

  logic        b_flush, b_in_valid, b_in_ready, b_in_err, b_in_halt;
  logic        b_out_valid, b_out_ready, b_out_err, b_out_halt, b_halted;
  logic [15:0] b_in_inst, b_in_pc, b_out_inst, b_out_pc;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt;
`endif

  pipe_stage_buf #(.DATA_W(16), .PC_W(16), .DEPTH(2), .NOP_WORD(16'h0800)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
    .in_err(a_in_err), .in_halt(a_in_halt),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inst(a_out_inst), .out_pc(a_out_pc),
    .out_err(a_out_err), .out_halt(a_out_halt), .halted(a_halted)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
`endif
  );

  pipe_stage_buf #(.DATA_W(16), .PC_W(16), .DEPTH(3), .NOP_WORD(16'h0800)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
    .in_err(b_in_err), .in_halt(b_in_halt),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst), .out_pc(b_out_pc),
    .out_err(b_out_err), .out_halt(b_out_halt), .halted(b_halted)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [15:0] inst, input logic [15:0] pc);
    a_in_valid = 1'b1; a_in_inst = inst; a_in_pc = pc;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_inst !== 16'h0800) begin errors++; $display("FAIL reset_out_inst got=%h exp=0800", a_out_inst); end
    checks++; if (a_out_pc !== 16'h0000) begin errors++; $display("FAIL reset_out_pc got=%h exp=0000", a_out_pc); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if (a_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0b exp=0", a_halted); end
    checks++; if ({a_out_err, a_out_halt} !== 2'b00) begin errors++; $display("FAIL reset_err_halt got=%b exp=00", {a_out_err, a_out_halt}); end
    checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b got v=%0b r=%0b exp v=0 r=1", b_out_valid, b_in_ready); end
    $display("reset: out_valid=%0b out_inst=%h in_ready=%0b", a_out_valid, a_out_inst, a_in_ready);
  endtask

  task automatic test_fill();
    a_out_ready = 1'b0;
    push_a(16'h1234, 16'h0002);
    checks++; if (a_out_valid !== 1'b1 || a_out_inst !== 16'h1234) begin errors++; $display("FAIL fill_first_head got v=%0b inst=%h exp v=1 inst=1234", a_out_valid, a_out_inst); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after1 got=%0b exp=1", a_in_ready); end
    push_a(16'h5678, 16'h0004);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got=%0b exp=0", a_in_ready); end
    checks++; if (a_out_inst !== 16'h1234 || a_out_pc !== 16'h0002) begin errors++; $display("FAIL fill_head got inst=%h pc=%h exp 1234/0002", a_out_inst, a_out_pc); end
    a_out_ready = 1'b1;
    step();
    checks++; if (a_out_inst !== 16'h5678 || a_out_pc !== 16'h0004) begin errors++; $display("FAIL fill_second got inst=%h pc=%h exp 5678/0004", a_out_inst, a_out_pc); end
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_inst !== 16'h0800) begin errors++; $display("FAIL fill_bubble got v=%0b inst=%h exp v=0 inst=0800", a_out_valid, a_out_inst); end
    a_out_ready = 1'b0;
    $display("fill: drained 1234, 5678 then bubble");
  endtask

  task automatic test_full_pop();
    a_out_ready = 1'b0;
    push_a(16'h1111, 16'h0012);
    push_a(16'h2222, 16'h0014);
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_inst = 16'h3333; a_in_pc = 16'h0016;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_refuse got=%0b exp=0", a_in_ready); end
    step();
    checks++; if (a_out_inst !== 16'h2222 || a_in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_after_pop got inst=%h r=%0b exp 2222 r=1", a_out_inst, a_in_ready); end
    step();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_inst !== 16'h3333) begin errors++; $display("FAIL fullpop_accept got v=%0b inst=%h exp v=1 inst=3333", a_out_valid, a_out_inst); end
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%0b exp=0", a_out_valid); end
    a_out_ready = 1'b0;
    $display("full_pop: 3333 accepted one cycle after refusal");
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    push_a(16'h4444, 16'h0020);
    push_a(16'h5555, 16'h0022);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_inst = 16'hABCD; a_in_pc = 16'h0024;
    a_out_ready = 1'b1;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_out_inst !== 16'h0800) begin errors++; $display("FAIL flush_bubble got v=%0b inst=%h exp v=0 inst=0800", a_out_valid, a_out_inst); end
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_inst === 16'hABCD) begin errors++; $display("FAIL flush_dropped got v=%0b inst=%h exp v=0 inst=0800", a_out_valid, a_out_inst); end
    a_out_ready = 1'b0;
    $display("flush: buffer emptied, ABCD dropped");
  endtask

  task automatic test_halt();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_inst = 16'h0000; a_in_pc = 16'h0030; a_in_halt = 1'b1;
    step();
    a_in_halt = 1'b0; a_in_inst = 16'h9999; a_in_pc = 16'h0032;
    checks++; if (a_halted !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL halt_enter got h=%0b r=%0b exp h=1 r=0", a_halted, a_in_ready); end
    checks++; if (a_out_valid !== 1'b1 || a_out_halt !== 1'b1 || a_out_inst !== 16'h0000) begin errors++; $display("FAIL halt_head got v=%0b oh=%0b inst=%h exp v=1 oh=1 inst=0000", a_out_valid, a_out_halt, a_out_inst); end
    a_out_ready = 1'b1;
    step();
    checks++; if (a_out_valid !== 1'b0 || a_out_halt !== 1'b0) begin errors++; $display("FAIL halt_drained got v=%0b oh=%0b exp v=0 oh=0", a_out_valid, a_out_halt); end
    checks++; if (a_halted !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL halt_sticky got h=%0b r=%0b exp h=1 r=0", a_halted, a_in_ready); end
    a_flush = 1'b1; a_in_valid = 1'b0;
    step();
    a_flush = 1'b0;
    checks++; if (a_halted !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL halt_release got h=%0b r=%0b exp h=0 r=1", a_halted, a_in_ready); end
    a_out_ready = 1'b0;
    $display("halt: entered, drained halt entry, released by flush");
  endtask

  task automatic test_wrap();
    int sent = 0;
    int recv = 0;
    int stalls = 0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      b_in_valid = (sent < 10);
      b_in_inst  = 16'hC000 + 16'(sent);
      b_in_pc    = 16'(2 * sent + 2);
      b_in_err   = sent[0];
      b_out_ready = ($urandom_range(0, 1) == 1);
      if (b_out_valid && !b_out_ready) stalls++;
      if (b_out_valid && b_out_ready) begin
        $display("wrap pop %0d: inst=%h pc=%h err=%0b", recv, b_out_inst, b_out_pc, b_out_err);
        checks++;
        if (b_out_inst !== 16'hC000 + 16'(recv) || b_out_pc !== 16'(2 * recv + 2) || b_out_err !== recv[0]) begin
          errors++;
          $display("FAIL wrap_entry_%0d got inst=%h pc=%h err=%0b exp inst=%h pc=%h err=%0b", recv, b_out_inst, b_out_pc, b_out_err, 16'hC000 + 16'(recv), 16'(2 * recv + 2), recv[0]);
        end
        recv++;
      end
      if (b_in_valid && b_in_ready) sent++;
      step();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    checks++; if (recv != 10) begin errors++; $display("FAIL wrap_timeout got=%0d exp=10 entries", recv); end
`ifdef PIPE_STAGE_PERF_EN
    checks++; if (b_stall_cnt !== 16'(stalls)) begin errors++; $display("FAIL wrap_stall_cnt got=%0d exp=%0d", b_stall_cnt, stalls); end
`endif
    $display("wrap: %0d entries received, %0d stall cycles", recv, stalls);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_inst = '0; a_in_pc = '0; a_in_err = 1'b0; a_in_halt = 1'b0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_inst = '0; b_in_pc = '0; b_in_err = 1'b0; b_in_halt = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_fill();
    test_full_pop();
    test_flush();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
